pipe_redirect_ctrl: RTL and testbench
=====================================

// Module: pipe_redirect_ctrl
// PURPOSE
//  Central redirect/stall controller for the fetch stage. Arbitrates PC redirect
//  sources: interrupt over execute-stage jump. Drives jump_flag/jump_addr/hold_flag
//  into the PC register and flush into the IF/ID pipeline registers.
//  Defers a redirect while the fetch bus is busy, then inserts flush bubbles.
// PARAMETERS
//  ADDR_W        32  instruction address width
//  FLUSH_CYCLES  2   cycles flush is asserted per redirect, including the issue cycle; legal 1..7
// PORTS
//  clk           in   1       system clock, all state on posedge
//  rst           in   1       asynchronous, active-low reset (0 = reset)
//  pc            in   ADDR_W  current PC register value
//  ex_jump_req   in   1       execute stage requests a taken jump/branch
//  ex_jump_addr  in   ADDR_W  jump target
//  ex_hold_req   in   1       multi-cycle execute op busy; stall front end
//  int_req       in   1       interrupt request, level; held until int_ack
//  int_vec       in   ADDR_W  interrupt handler address
//  bus_busy      in   1       fetch bus cannot accept a new address this cycle
//  jump_flag     out  1       one-cycle redirect strobe to PC register (registered)
//  jump_addr     out  ADDR_W  redirect target, valid while jump_flag=1 (registered)
//  hold_flag     out  3       [0]=hold PC, [1]=hold IF, [2]=hold ID
//  flush         out  1       clear IF/ID pipeline registers (registered)
//  int_ack       out  1       one-cycle pulse, coincident with interrupt redirect strobe
//  int_epc       out  ADDR_W  return address of the taken interrupt; holds until next interrupt
// BEHAVIOUR
//  Reset: state=IDLE; jump_flag, flush, int_ack = 0; jump_addr, int_epc, pend_addr = 0; flush counter = 0.
//  Reset mid-operation discards any pending redirect.
//  Request selection, same cycle: int_req wins over ex_jump_req.
//   If both are asserted, int_epc <= ex_jump_addr; if interrupt only, int_epc <= pc.
//   Losing ex_jump is dropped.
//  States:
//   IDLE:
//    - Request and !bus_busy: next cycle jump_flag=1, jump_addr=target, flush=1 (int_ack=1 if interrupt).
//      Go to FLUSH with count = FLUSH_CYCLES-1.
//    - Request and bus_busy: pend_addr <= target; pend_is_int recorded; int_epc latched now.
//      Go to PEND.
//   PEND:
//    - hold_flag = 3'b111.
//    - An int_req arriving while pend_is_int=0 replaces pend_addr with int_vec,
//      sets pend_is_int, and sets int_epc <= pend_addr.
//    - ex_jump_req is ignored.
//    - When bus_busy=0: issue strobe exactly as IDLE does and go to FLUSH.
//   FLUSH:
//    - flush stays 1 until count reaches 0, then return to IDLE.
//    - If FLUSH_CYCLES=1, return to IDLE directly after the issue cycle.
//    - All requests are ignored; int_req stays level and is taken in IDLE.
//  Latency: request sampled at edge N -> jump_flag high during cycle N+1 -> PC loads target at edge N+1.
//  jump_flag and int_ack are never high for two consecutive cycles.
//  hold_flag is combinational = {3{ex_hold_req}} | (state==PEND ? 3'b111 : 3'b000).
//   No registered delay on ex_hold_req.
//   The PC register gives jump_flag priority over hold.
//  A request in IDLE while ex_hold_req=1 is still accepted; the redirect overrides the stall.
//  Addresses pass through unmodified; no alignment checking.
// TESTING
//  1. ex_jump_req=1, addr=0x100, bus_busy=0 at edge N
//     -> jump_flag=1, jump_addr=0x100 in cycle N+1 only; flush high N+1..N+2; then IDLE.
//  2. int_req and ex_jump_req (addr 0x200) together, int_vec=0x80
//     -> jump_addr=0x80, int_ack=1, int_epc=0x200; no redirect to 0x200.
//  3. ex_jump to 0x40 with bus_busy=1 for 3 cycles
//     -> hold_flag=3'b111 for those 3 cycles; jump_flag for 0x40 one cycle after bus_busy falls.
//  4. In PEND for ex_jump to 0x40, int_req rises (vec 0x80)
//     -> single redirect to 0x80, int_ack=1, int_epc=0x40.
//  5. ex_hold_req=1 for 4 cycles in IDLE -> hold_flag=3'b111 in those same cycles; jump_flag=0.
//  6. rst low during PEND -> all outputs at reset values immediately; no redirect after rst rises.

Source files
------------

// File: rtl/pipe_redirect_ctrl.sv
// Fetch-stage redirect/stall controller: arbitrates interrupt over execute jump,
// defers redirects while the fetch bus is busy, then issues a strobe plus flush bubbles.
module pipe_redirect_ctrl #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ex_jump_req,
  input  logic [ADDR_W-1:0] ex_jump_addr,
  input  logic              ex_hold_req,
  input  logic              int_req,
  input  logic [ADDR_W-1:0] int_vec,
  input  logic              bus_busy,
  output logic              jump_flag,
  output logic [ADDR_W-1:0] jump_addr,
  output logic [2:0]        hold_flag,
  output logic              flush,
  output logic              int_ack,
  output logic [ADDR_W-1:0] int_epc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t            state;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_is_int;
  logic [2:0]        cnt;

  logic              req;
  logic              sel_int;
  logic [ADDR_W-1:0] sel_addr;
  logic              epc_load;
  logic [ADDR_W-1:0] epc_val;

  // Candidate redirect for this cycle; IDLE and PEND share the issue/defer path below.
  always_comb begin
    req      = 1'b0;
    sel_int  = pend_is_int;
    sel_addr = pend_addr;
    epc_load = 1'b0;
    epc_val  = int_epc;
    case (state)
      IDLE: begin
        req      = int_req | ex_jump_req;
        sel_int  = int_req;
        sel_addr = int_req ? int_vec : ex_jump_addr;
        epc_load = int_req;
        epc_val  = ex_jump_req ? ex_jump_addr : pc;
      end
      PEND: begin
        req = 1'b1;
        if (!pend_is_int && int_req) begin
          sel_int  = 1'b1;
          sel_addr = int_vec;
          epc_load = 1'b1;
          epc_val  = pend_addr;
        end
      end
      default: ;
    endcase
  end

  assign hold_flag = {3{ex_hold_req}} | ((state == PEND) ? 3'b111 : 3'b000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      jump_flag   <= 1'b0;
      jump_addr   <= '0;
      flush       <= 1'b0;
      int_ack     <= 1'b0;
      int_epc     <= '0;
      pend_addr   <= '0;
      pend_is_int <= 1'b0;
      cnt         <= '0;
    end else begin
      jump_flag <= 1'b0;
      int_ack   <= 1'b0;
      case (state)
        IDLE, PEND: begin
          if (req) begin
            if (epc_load) int_epc <= epc_val;
            if (!bus_busy) begin
              jump_flag <= 1'b1;
              jump_addr <= sel_addr;
              int_ack   <= sel_int;
              flush     <= 1'b1;
              cnt       <= FLUSH_INIT;
              state     <= FLUSH;
            end else begin
              pend_addr   <= sel_addr;
              pend_is_int <= sel_int;
              state       <= PEND;
            end
          end
        end
        FLUSH: begin
          if (cnt == 3'd0) begin
            flush <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_redirect_ctrl.sv
// Directed bench for pipe_redirect_ctrl with hand-computed expectations.
module tb_pipe_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        ex_jump_req;
  logic [31:0] ex_jump_addr;
  logic        ex_hold_req;
  logic        int_req;
  logic [31:0] int_vec;
  logic        bus_busy;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic [2:0]  hold_flag;
  logic        flush;
  logic        int_ack;
  logic [31:0] int_epc;

  int checks;
  int errors;

  pipe_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .ex_jump_req  (ex_jump_req),
    .ex_jump_addr (ex_jump_addr),
    .ex_hold_req  (ex_hold_req),
    .int_req      (int_req),
    .int_vec      (int_vec),
    .bus_busy     (bus_busy),
    .jump_flag    (jump_flag),
    .jump_addr    (jump_addr),
    .hold_flag    (hold_flag),
    .flush        (flush),
    .int_ack      (int_ack),
    .int_epc      (int_epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    pc = 32'h0000_1000;
    ex_jump_req = 1'b0;
    ex_jump_addr = '0;
    ex_hold_req = 1'b0;
    int_req = 1'b0;
    int_vec = '0;
    bus_busy = 1'b0;

    #12;
    chk("rst_jump_flag", {31'd0, jump_flag}, 32'd0);
    chk("rst_jump_addr", jump_addr, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_int_ack", {31'd0, int_ack}, 32'd0);
    chk("rst_int_epc", int_epc, 32'd0);
    chk("rst_hold", {29'd0, hold_flag}, 32'd0);
    rst = 1'b1;
    tick();

    // 1: plain jump, no bus stall
    ex_jump_req = 1'b1; ex_jump_addr = 32'h100;
    tick();
    ex_jump_req = 1'b0;
    chk("t1_jf_n1", {31'd0, jump_flag}, 32'd1);
    chk("t1_addr_n1", jump_addr, 32'h100);
    chk("t1_flush_n1", {31'd0, flush}, 32'd1);
    chk("t1_ack_n1", {31'd0, int_ack}, 32'd0);
    tick();
    chk("t1_jf_n2", {31'd0, jump_flag}, 32'd0);
    chk("t1_flush_n2", {31'd0, flush}, 32'd1);
    tick();
    chk("t1_flush_n3", {31'd0, flush}, 32'd0);
    chk("t1_jf_n3", {31'd0, jump_flag}, 32'd0);

    // 2: interrupt and jump together
    int_req = 1'b1; int_vec = 32'h80; ex_jump_req = 1'b1; ex_jump_addr = 32'h200;
    tick();
    int_req = 1'b0; ex_jump_req = 1'b0;
    chk("t2_jf", {31'd0, jump_flag}, 32'd1);
    chk("t2_addr", jump_addr, 32'h80);
    chk("t2_ack", {31'd0, int_ack}, 32'd1);
    chk("t2_epc", int_epc, 32'h200);
    tick();
    chk("t2_jf_after", {31'd0, jump_flag}, 32'd0);
    chk("t2_ack_after", {31'd0, int_ack}, 32'd0);
    tick();
    tick();
    chk("t2_no_redirect", {31'd0, jump_flag}, 32'd0);
    chk("t2_epc_hold", int_epc, 32'h200);

    // 3: jump deferred by bus busy
    ex_jump_req = 1'b1; ex_jump_addr = 32'h40; bus_busy = 1'b1;
    #1;
    chk("t3_hold_idle", {29'd0, hold_flag}, 32'd0);
    tick();
    ex_jump_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_pend", {29'd0, hold_flag}, 32'h7);
      chk("t3_jf_pend", {31'd0, jump_flag}, 32'd0);
      if (i < 2) tick();
    end
    bus_busy = 1'b0;
    tick();
    chk("t3_jf", {31'd0, jump_flag}, 32'd1);
    chk("t3_addr", jump_addr, 32'h40);
    chk("t3_ack", {31'd0, int_ack}, 32'd0);
    chk("t3_hold_after", {29'd0, hold_flag}, 32'd0);
    tick();
    tick();

    // 4: interrupt replaces pending jump
    ex_jump_req = 1'b1; ex_jump_addr = 32'h40; bus_busy = 1'b1;
    tick();
    ex_jump_req = 1'b0;
    int_req = 1'b1; int_vec = 32'h80;
    tick();
    chk("t4_jf_pend", {31'd0, jump_flag}, 32'd0);
    chk("t4_epc_pend", int_epc, 32'h40);
    bus_busy = 1'b0;
    tick();
    int_req = 1'b0;
    chk("t4_jf", {31'd0, jump_flag}, 32'd1);
    chk("t4_addr", jump_addr, 32'h80);
    chk("t4_ack", {31'd0, int_ack}, 32'd1);
    chk("t4_epc", int_epc, 32'h40);
    tick();
    chk("t4_jf_after", {31'd0, jump_flag}, 32'd0);
    tick();
    chk("t4_single", {31'd0, jump_flag}, 32'd0);
    tick();

    // 5: execute hold in IDLE
    ex_hold_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5_hold", {29'd0, hold_flag}, 32'h7);
      chk("t5_jf", {31'd0, jump_flag}, 32'd0);
      tick();
    end
    ex_hold_req = 1'b0;
    #1;
    chk("t5_hold_off", {29'd0, hold_flag}, 32'd0);

    // 6: reset during PEND
    ex_jump_req = 1'b1; ex_jump_addr = 32'h300; bus_busy = 1'b1;
    tick();
    ex_jump_req = 1'b0;
    chk("t6_hold_pend", {29'd0, hold_flag}, 32'h7);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_jf", {31'd0, jump_flag}, 32'd0);
    chk("t6_addr", jump_addr, 32'd0);
    chk("t6_flush", {31'd0, flush}, 32'd0);
    chk("t6_ack", {31'd0, int_ack}, 32'd0);
    chk("t6_epc", int_epc, 32'd0);
    chk("t6_hold", {29'd0, hold_flag}, 32'd0);
    rst = 1'b1;
    bus_busy = 1'b0;
    tick();
    chk("t6_no_jf1", {31'd0, jump_flag}, 32'd0);
    tick();
    chk("t6_no_jf2", {31'd0, jump_flag}, 32'd0);

    // 7: interrupt raised during FLUSH waits until IDLE; epc = pc
    pc = 32'h1000;
    ex_jump_req = 1'b1; ex_jump_addr = 32'h500;
    tick();
    ex_jump_req = 1'b0;
    chk("t7_jf_jump", {31'd0, jump_flag}, 32'd1);
    int_req = 1'b1; int_vec = 32'h90;
    tick();
    chk("t7_jf_f1", {31'd0, jump_flag}, 32'd0);
    tick();
    chk("t7_jf_f2", {31'd0, jump_flag}, 32'd0);
    chk("t7_flush_f2", {31'd0, flush}, 32'd0);
    tick();
    int_req = 1'b0;
    chk("t7_jf_int", {31'd0, jump_flag}, 32'd1);
    chk("t7_addr_int", jump_addr, 32'h90);
    chk("t7_ack", {31'd0, int_ack}, 32'd1);
    chk("t7_epc", int_epc, 32'h1000);
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
